// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers and the PC redirect mux.
package pipe_pkg;

   // Default bundle widths matching the original ID/EX latch.
   localparam int unsigned DATA_W_DEF = 149;
   localparam int unsigned CTRL_W_DEF = 16;
   localparam int unsigned PC_W_DEF   = 32;
   localparam int unsigned CNT_W_DEF  = 16;

   localparam logic [PC_W_DEF-1:0] PC_RESET = '0;

   // Source of the next stage PC, in increasing priority.
   typedef enum logic [1:0] {
      PC_SEL_IN,
      PC_SEL_EX,
      PC_SEL_MEM
   } pc_sel_e;

endpackage

// File: rtl/pipe_pc_sel.sv
// Priority PC redirect mux: MEM branch, then EX branch, then the incoming PC.
// Shared with the fetch stage.
module pipe_pc_sel
   import pipe_pkg::*;
#(
   parameter int unsigned PC_W = PC_W_DEF
) (
   input  logic            i_mem_branch_en,
   input  logic            i_ex_branch_en,
   input  logic            i_is_branch,
   input  logic [PC_W-1:0] i_in_pc,
   input  logic [PC_W-1:0] i_if_pc,
   input  logic [PC_W-1:0] i_ex_target,
   output logic [PC_W-1:0] o_pc
);

   pc_sel_e w_sel;

   // Redirects apply only to branch candidates; the MEM branch is older and wins.
   always_comb begin
      w_sel = PC_SEL_IN;
      if (i_is_branch && i_mem_branch_en) begin
         w_sel = PC_SEL_MEM;
      end else if (i_is_branch && i_ex_branch_en) begin
         w_sel = PC_SEL_EX;
      end
   end

   // Select the PC named by the decoded source.
   always_comb begin
      o_pc = i_in_pc;
      unique case (w_sel)
         PC_SEL_MEM: o_pc = i_if_pc;
         PC_SEL_EX:  o_pc = i_ex_target;
         PC_SEL_IN:  o_pc = i_in_pc;
         default:    o_pc = i_in_pc;
      endcase
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// synchronous flush, bubble insertion and PC redirect on load.
// Optional stall/flush statistics counters: define PIPE_STAGE_REG_STATS_EN.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned CTRL_W = CTRL_W_DEF,
   parameter int unsigned PC_W   = PC_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   input  logic [CTRL_W-1:0] i_in_ctrl,
   input  logic              i_in_is_branch,
   input  logic [PC_W-1:0]   i_in_pc,
   input  logic [PC_W-1:0]   i_if_pc,
   input  logic [PC_W-1:0]   i_ex_target,
   input  logic              i_mem_branch_en,
   input  logic              i_ex_branch_en,
   input  logic              i_flush,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic [CTRL_W-1:0] o_out_ctrl,
   output logic [PC_W-1:0]   o_out_pc,
   output logic [CNT_W-1:0]  o_stat_stall,
   output logic [CNT_W-1:0]  o_stat_flush
);

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic [CTRL_W-1:0] r_out_ctrl;
   logic [PC_W-1:0]   r_out_pc;
   logic              w_in_ready;
   logic [PC_W-1:0]   w_next_pc;

   // No skid buffer: accept whenever empty or draining this cycle.
   assign w_in_ready = ~r_out_valid | i_out_ready;

   pipe_pc_sel #(
      .PC_W (PC_W)
   ) u_pc_sel (
      .i_mem_branch_en (i_mem_branch_en),
      .i_ex_branch_en  (i_ex_branch_en),
      .i_is_branch     (i_in_is_branch),
      .i_in_pc         (i_in_pc),
      .i_if_pc         (i_if_pc),
      .i_ex_target     (i_ex_target),
      .o_pc            (w_next_pc)
   );

   // Stage contents: flush beats load, load beats bubble; otherwise hold (stall).
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ctrl  <= '0;
         r_out_pc    <= PC_W'(PC_RESET);
      end else if (i_flush) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ctrl  <= '0;
         r_out_pc    <= PC_W'(PC_RESET);
      end else if (w_in_ready) begin
         r_out_valid <= i_in_valid;
         if (i_in_valid) begin
            r_out_data <= i_in_data;
            r_out_ctrl <= i_in_ctrl;
            r_out_pc   <= w_next_pc;
         end else begin
            // Bubble: an all-zero control bundle is a NOP downstream.
            r_out_data <= '0;
            r_out_ctrl <= '0;
            r_out_pc   <= PC_W'(PC_RESET);
         end
      end
   end

   assign o_in_ready  = w_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_out_ctrl  = r_out_ctrl;
   assign o_out_pc    = r_out_pc;

`ifdef PIPE_STAGE_REG_STATS_EN
   logic [CNT_W-1:0] r_stat_stall;
   logic [CNT_W-1:0] r_stat_flush;

   // Saturating stall and flush counters; a flushed stall cycle is not a stall.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_stat_stall <= '0;
         r_stat_flush <= '0;
      end else begin
         if (r_out_valid && !i_out_ready && !i_flush && (r_stat_stall != '1)) begin
            r_stat_stall <= r_stat_stall + CNT_W'(1);
         end
         if (i_flush && (r_stat_flush != '1)) begin
            r_stat_flush <= r_stat_flush + CNT_W'(1);
         end
      end
   end

   assign o_stat_stall = r_stat_stall;
   assign o_stat_flush = r_stat_flush;
`else
   assign o_stat_stall = '0;
   assign o_stat_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed plan followed by random traffic.
module tb_pipe_stage_reg;

   localparam int unsigned DW = 149;
   localparam int unsigned CW = 16;
   localparam int unsigned PW = 32;
   localparam int unsigned NW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic [CW-1:0] in_ctrl = '0;
   logic          in_is_branch = 1'b0;
   logic [PW-1:0] in_pc = '0;
   logic [PW-1:0] if_pc = '0;
   logic [PW-1:0] ex_target = '0;
   logic          mem_branch_en = 1'b0;
   logic          ex_branch_en = 1'b0;
   logic          flush = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic [PW-1:0] out_pc;
   logic [NW-1:0] stat_stall;
   logic [NW-1:0] stat_flush;

   pipe_stage_reg #(
      .DATA_W (DW),
      .CTRL_W (CW),
      .PC_W   (PW),
      .CNT_W  (NW)
   ) dut (
      .i_clk           (clk),
      .i_reset_n       (rst_n),
      .i_in_valid      (in_valid),
      .o_in_ready      (in_ready),
      .i_in_data       (in_data),
      .i_in_ctrl       (in_ctrl),
      .i_in_is_branch  (in_is_branch),
      .i_in_pc         (in_pc),
      .i_if_pc         (if_pc),
      .i_ex_target     (ex_target),
      .i_mem_branch_en (mem_branch_en),
      .i_ex_branch_en  (ex_branch_en),
      .i_flush         (flush),
      .o_out_valid     (out_valid),
      .i_out_ready     (out_ready),
      .o_out_data      (out_data),
      .o_out_ctrl      (out_ctrl),
      .o_out_pc        (out_pc),
      .o_stat_stall    (stat_stall),
      .o_stat_flush    (stat_flush)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          valid;
      logic [DW-1:0] data;
      logic [CW-1:0] ctrl;
      logic [PW-1:0] pc;
      int unsigned   stalls;
      int unsigned   flushes;
   } exp_t;

   exp_t q[$];
   exp_t m;  // reference contents of the stage as seen after the last edge
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [159:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return t[DW-1:0];
   endfunction

   task automatic model_clear();
      m.valid = 1'b0;
      m.data = '0;
      m.ctrl = '0;
      m.pc = '0;
      m.stalls = 0;
      m.flushes = 0;
   endtask

   // Apply one cycle of inputs, check in_ready, predict the next stage contents.
   task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic br, input logic [PW-1:0] pc, input logic [PW-1:0] ifpc,
                        input logic [PW-1:0] ext, input logic mem, input logic ex,
                        input logic fl, input logic ordy);
      bit accept;
      @(negedge clk);
      in_valid = v; in_data = d; in_ctrl = c; in_is_branch = br; in_pc = pc;
      if_pc = ifpc; ex_target = ext; mem_branch_en = mem; ex_branch_en = ex;
      flush = fl; out_ready = ordy;
      #1;
      accept = !m.valid || ordy;
      chk("in_ready", 160'(in_ready), 160'(accept));
      if (fl) begin
         m.flushes++;
         m.valid = 1'b0; m.data = '0; m.ctrl = '0; m.pc = '0;
      end else if (accept) begin
         m.valid = v;
         m.data  = v ? d : '0;
         m.ctrl  = v ? c : '0;
         if (!v)            m.pc = '0;
         else if (br && mem) m.pc = ifpc;
         else if (br && ex)  m.pc = ext;
         else                m.pc = pc;
      end else begin
         m.stalls++;
      end
      q.push_back(m);
   endtask

   task automatic ld(input logic [PW-1:0] pc, input logic [DW-1:0] d);
      drive(1'b1, d, CW'($urandom), 1'b0, pc, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_valid"}, 160'(out_valid), 160'(0));
      chk({name, "_data"},  160'(out_data),  160'(0));
      chk({name, "_ctrl"},  160'(out_ctrl),  160'(0));
      chk({name, "_pc"},    160'(out_pc),    160'(0));
      chk({name, "_stall"}, 160'(stat_stall), 160'(0));
      chk({name, "_flush"}, 160'(stat_flush), 160'(0));
   endtask

   // Monitor: the register presents new contents after every edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("out_valid", 160'(out_valid), 160'(e.valid));
            chk("out_data",  160'(out_data),  160'(e.data));
            chk("out_ctrl",  160'(out_ctrl),  160'(e.ctrl));
            chk("out_pc",    160'(out_pc),    160'(e.pc));
`ifdef PIPE_STAGE_REG_STATS_EN
            chk("stat_stall", 160'(stat_stall), 160'(e.stalls));
            chk("stat_flush", 160'(stat_flush), 160'(e.flushes));
`else
            chk("stat_stall", 160'(stat_stall), 160'(0));
            chk("stat_flush", 160'(stat_flush), 160'(0));
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      model_clear();
      #2;
      chk_zero("reset");
      #1 rst_n = 1'b1;

      // Streaming
      for (int i = 0; i < 4; i++) ld(PW'(32'h0040_0000 + 4 * i), rnd_data());

      // Stall for three cycles, then release into a new load
      ld(32'h0040_0010, DW'(16'h1234));
      for (int i = 0; i < 3; i++)
         drive(1'b1, rnd_data(), 16'hbeef, 1'b1, 32'h1, 32'h2, 32'h3, 1'b1, 1'b1, 1'b0, 1'b0);
      ld(32'h0040_0014, rnd_data());

      // Redirect priority
      drive(1'b1, rnd_data(), 16'h1, 1'b1, 32'h0040_0020, 32'h0040_0100, 32'h0040_0200,
            1'b1, 1'b1, 1'b0, 1'b1);
      drive(1'b1, rnd_data(), 16'h2, 1'b1, 32'h0040_0024, 32'h0040_0100, 32'h0040_0200,
            1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b1, rnd_data(), 16'h3, 1'b0, 32'h0040_0028, 32'h0040_0100, 32'h0040_0200,
            1'b1, 1'b1, 1'b0, 1'b1);

      // Flush while stalled, then confirm acceptance resumes
      drive(1'b1, rnd_data(), 16'h4, 1'b0, 32'h0040_002c, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, rnd_data(), 16'h5, 1'b0, 32'h0040_0030, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, rnd_data(), 16'h6, 1'b0, 32'h0040_0034, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Bubble after valid traffic
      ld(32'h0040_0038, rnd_data());
      drive(1'b0, rnd_data(), 16'h7, 1'b0, 32'h0040_003c, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Asynchronous reset between edges while stalled
      ld(32'h0040_0040, rnd_data());
      drive(1'b1, rnd_data(), 16'h8, 1'b0, 32'h0040_0044, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_zero("async_reset");
      model_clear();
      q.delete();
      #1 rst_n = 1'b1;
      ld(32'h0040_0000, rnd_data());

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(3, 0) != 0, rnd_data(), CW'($urandom), $urandom_range(1, 0) == 1,
               $urandom, $urandom, $urandom, $urandom_range(9, 0) < 3,
               $urandom_range(9, 0) < 3, $urandom_range(15, 0) == 0,
               $urandom_range(9, 0) < 7);
      end

      @(posedge clk);
      #2;
      chk("queue_drained", 160'(q.size()), 160'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register, the successor to the fixed-width ID/EX latch. It carries a data bundle, a control bundle and a stage PC, with a valid/ready handshake for stalls, a synchronous flush, and bubble insertion. The PC redirect uses the same priority as the existing ID/EX latch: MEM branch first, then EX branch, then the incoming PC. One instance sits at each stage boundary: IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
DATA_W, 149, width of the data bundle (operands, immediates, register numbers)
CTRL_W, 16, width of the control bundle (excludes the is-branch flag)
PC_W, 32, width of the PC and branch-target fields
CNT_W, 16, width of the statistics counters (used only with the optional feature)

Ports:
clk  in  1  clock, rising-edge active
reset  in  1  asynchronous, active-low reset
in_valid  in  1  upstream stage presents a valid instruction
in_ready  out  1  this register can accept a new instruction this cycle
in_data  in  DATA_W  data bundle from upstream
in_ctrl  in  CTRL_W  control bundle from upstream
in_is_branch  in  1  instruction is a branch-delay or redirect candidate; gates PC substitution
in_pc  in  PC_W  PC of the incoming instruction
if_pc  in  PC_W  current fetch PC, used when a MEM-stage branch is taken
ex_target  in  PC_W  EX-stage conditional branch target
mem_branch_en  in  1  MEM-stage branch taken
ex_branch_en  in  1  EX-stage branch taken
flush  in  1  kill the contents of this stage
out_valid  out  1  register holds a valid instruction
out_ready  in  1  downstream stage accepts this cycle
out_data  out  DATA_W  registered data bundle
out_ctrl  out  CTRL_W  registered control bundle
out_pc  out  PC_W  registered stage PC
stat_stall  out  CNT_W  stall-cycle count (optional feature only)
stat_flush  out  CNT_W  flush count (optional feature only)

Behaviour:
- Reset (reset=0, asynchronous): out_valid, out_data, out_ctrl and out_pc are 0; stats counters are 0.
- in_ready = ~out_valid | out_ready. This is combinational, with no skid storage. Throughput is 1 per cycle; latency is 1 cycle.
- Each rising edge resolves in this priority order:
  1. flush=1: out_valid, out_data, out_ctrl and out_pc go to 0, regardless of in_valid, out_ready or a held entry. A zeroed control bundle is a NOP.
  2. in_ready=1 and in_valid=1 (load):
     - out_valid goes to 1; out_data and out_ctrl take in_data and in_ctrl.
     - out_pc: if mem_branch_en and in_is_branch, if_pc; else if ex_branch_en and in_is_branch, ex_target; else in_pc.
  3. in_ready=1 and in_valid=0 (bubble): out_valid, out_data, out_ctrl and out_pc go to 0.
  4. out_valid=1 and out_ready=0 (stall): all outputs hold. Branch-enable inputs are ignored, so no late PC substitution.
- mem_branch_en and ex_branch_en both 1: the MEM branch wins.
- Branch enables with in_is_branch=0: out_pc = in_pc.
- flush while stalled: the held entry is discarded and in_ready reads 1 on the next cycle.
- When out_valid=0, out_ready is don't-care.
- Reset asserted mid-stall clears state immediately. After release, the first edge with in_valid=1 loads normally.
- All widths pass through unchanged; there is no arithmetic on the datapath.

Optional Feature:
Macro PIPE_STAGE_REG_STATS_EN.
- Defined:
  - stat_stall increments on each edge where out_valid=1 and out_ready=0 and flush=0.
  - stat_flush increments on each edge with flush=1.
  - Both saturate at 2^CNT_W-1 and reset to 0.
- Undefined: stat_stall and stat_flush are tied to 0 and no counter flops exist.

Decomposition:
- Shared package pipe_pkg holds:
  - default widths DATA_W_DEF=149, CTRL_W_DEF=16, PC_W_DEF=32
  - constant PC_RESET='0
  - typedef pc_sel_e {PC_SEL_IN, PC_SEL_EX, PC_SEL_MEM}
- One sub-module, pipe_pc_sel: combinational priority mux producing the next out_pc from the branch enables, in_is_branch and the three candidate PCs. It is reused by the fetch stage.
- Statistics counters stay inline.

Test Plan:
1. Streaming: 4 back-to-back loads with in_valid=1, out_ready=1 and in_pc 0x00400000, 04, 08, 0C → out_pc shows the same sequence one cycle later; out_valid stays 1 and in_ready stays 1.
2. Stall: out_ready=0 for 3 cycles holding in_data=0x1234 → out_data stays 0x1234 and in_ready=0; with the optional feature defined, stat_stall=3. On release, the next input loads.
3. Redirect priority: in_is_branch=1, mem_branch_en=1, ex_branch_en=1, if_pc=0x00400100, ex_target=0x00400200 → out_pc=0x00400100. Same with mem_branch_en=0 → 0x00400200. Same with in_is_branch=0 → in_pc.
4. Flush during stall: out_valid=1, out_ready=0, flush=1 → next cycle out_valid=0, out_data=0, out_pc=0 and in_ready=1; stat_flush=1.
5. Bubble: in_valid=0, out_ready=1 after valid traffic → out_valid=0 and out_ctrl=0 the next cycle.
6. Async reset mid-stall: reset pulled low between edges → outputs 0 immediately; after release, in_valid=1 with in_pc=0x00400000 → out_pc=0x00400000 one cycle later.
